btn_step_repeater: RTL and testbench

Converts the two debounced push-button levels (increment, decrement) into single-cycle step pulses with hold-to-repeat. It sits between the button debouncers and the up/down digit counter, so one press yields exactly one count. Holding a button auto-repeats after a delay. Conflicting or stale button states never produce steps.

---
 rtl/btn_step_repeater.sv | 112 +++++++++++
 tb/tb_btn_step_repeater.sv | 213 +++++++++++++++++++++
 2 files changed

// File: rtl/btn_step_repeater.sv
// Turns debounced increment/decrement button levels into one-cycle step pulses,
// with optional hold-to-repeat; conflicting or stale button states never step.
module btn_step_repeater #(
  parameter int unsigned HOLD_CYCLES   = 25_000_000,
  parameter int unsigned REPEAT_CYCLES = 5_000_000
) (
  input  logic FPGA_clk,
  input  logic rst,
  input  logic incr_lvl,
  input  logic decr_lvl,
  input  logic repeat_en,
  output logic incr_step,
  output logic decr_step,
  output logic busy
);

  localparam int unsigned MAX_CYCLES = (HOLD_CYCLES > REPEAT_CYCLES) ? HOLD_CYCLES : REPEAT_CYCLES;
  localparam int unsigned CNT_W      = $clog2(MAX_CYCLES);
  localparam logic [CNT_W-1:0] HOLD_LAST   = CNT_W'(HOLD_CYCLES - 1);
  localparam logic [CNT_W-1:0] REPEAT_LAST = CNT_W'(REPEAT_CYCLES - 1);

  typedef enum logic [1:0] {
    ST_RELEASE = 2'd0,
    ST_IDLE    = 2'd1,
    ST_HOLD    = 2'd2,
    ST_REPEAT  = 2'd3
  } state_e;

  state_e           state_q;
  logic [CNT_W-1:0] timer_q;
  logic             dir_q;
  logic             incr_step_q;
  logic             decr_step_q;
  logic             busy_q;

  logic             own_c;
  logic             other_c;
  logic [CNT_W-1:0] last_c;

  // dir_q = 0 tracks the increment button, 1 tracks the decrement button
  assign own_c   = dir_q ? decr_lvl : incr_lvl;
  assign other_c = dir_q ? incr_lvl : decr_lvl;
  assign last_c  = (state_q == ST_HOLD) ? HOLD_LAST : REPEAT_LAST;

  always_ff @(posedge FPGA_clk or negedge rst) begin
    if (!rst) begin
      state_q     <= ST_RELEASE;
      timer_q     <= '0;
      dir_q       <= 1'b0;
      incr_step_q <= 1'b0;
      decr_step_q <= 1'b0;
      busy_q      <= 1'b1;
    end else begin
      incr_step_q <= 1'b0;
      decr_step_q <= 1'b0;
      case (state_q)
        ST_RELEASE: begin
          if (!incr_lvl && !decr_lvl) begin
            state_q <= ST_IDLE;
            busy_q  <= 1'b0;
          end
        end
        ST_IDLE: begin
          if (incr_lvl && !decr_lvl) begin
            incr_step_q <= 1'b1;
            dir_q       <= 1'b0;
            timer_q     <= '0;
            state_q     <= ST_HOLD;
            busy_q      <= 1'b1;
          end else if (decr_lvl && !incr_lvl) begin
            decr_step_q <= 1'b1;
            dir_q       <= 1'b1;
            timer_q     <= '0;
            state_q     <= ST_HOLD;
            busy_q      <= 1'b1;
          end else if (incr_lvl && decr_lvl) begin
            state_q <= ST_RELEASE;
            busy_q  <= 1'b1;
          end
        end
        ST_HOLD, ST_REPEAT: begin
          // Conflict beats release, release beats any timing activity
          if (other_c) begin
            state_q <= ST_RELEASE;
            busy_q  <= 1'b1;
          end else if (!own_c) begin
            state_q <= ST_IDLE;
            busy_q  <= 1'b0;
          end else if (!repeat_en) begin
            timer_q <= '0;
          end else if (timer_q == last_c) begin
            incr_step_q <= ~dir_q;
            decr_step_q <= dir_q;
            timer_q     <= '0;
            state_q     <= ST_REPEAT;
          end else begin
            timer_q <= timer_q + CNT_W'(1);
          end
        end
        default: begin
          state_q <= ST_RELEASE;
          busy_q  <= 1'b1;
        end
      endcase
    end
  end

  assign incr_step = incr_step_q;
  assign decr_step = decr_step_q;
  assign busy      = busy_q;

endmodule

// File: tb/tb_btn_step_repeater.sv
// Scoreboard bench for btn_step_repeater: stimulus queues expected pulses
// (edge number + direction), a negedge monitor pops and compares them.
module tb_btn_step_repeater;

  logic FPGA_clk = 1'b0;
  logic rst;
  logic incr_lvl;
  logic decr_lvl;
  logic repeat_en;
  logic incr_step;
  logic decr_step;
  logic busy;

  typedef struct {
    int edge_n;
    bit dir;
  } exp_t;

  exp_t exp_q[$];
  exp_t mon_e;
  int   edge_cnt = 0;
  int   checks   = 0;
  int   errors   = 0;
  int   k;
  int   j;

  btn_step_repeater #(
    .HOLD_CYCLES  (8),
    .REPEAT_CYCLES(3)
  ) dut (
    .FPGA_clk (FPGA_clk),
    .rst      (rst),
    .incr_lvl (incr_lvl),
    .decr_lvl (decr_lvl),
    .repeat_en(repeat_en),
    .incr_step(incr_step),
    .decr_step(decr_step),
    .busy     (busy)
  );

  always #5 FPGA_clk = ~FPGA_clk;

  always @(posedge FPGA_clk) edge_cnt <= edge_cnt + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d (edge %0d)", name, act, req, edge_cnt);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge FPGA_clk);
  endtask

  task automatic push(input int e, input bit d);
    exp_t x;
    x.edge_n = e;
    x.dir    = d;
    exp_q.push_back(x);
  endtask

  // Monitor: every visible step pulse must match the head of the scoreboard
  always @(negedge FPGA_clk) begin
    if (exp_q.size() > 0 && exp_q[0].edge_n < edge_cnt) begin
      checks++;
      errors++;
      $display("FAIL missed_pulse: no pulse observed, expected dir %0d at edge %0d", exp_q[0].dir, exp_q[0].edge_n);
      void'(exp_q.pop_front());
    end
    if (incr_step === 1'b1 || decr_step === 1'b1) begin
      checks++;
      if (incr_step === 1'b1 && decr_step === 1'b1) begin
        errors++;
        $display("FAIL both_steps: incr and decr high together at edge %0d", edge_cnt);
      end else if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_pulse: incr=%0d decr=%0d at edge %0d, expected none", incr_step, decr_step, edge_cnt);
      end else begin
        mon_e = exp_q.pop_front();
        if (mon_e.edge_n != edge_cnt || mon_e.dir != decr_step) begin
          errors++;
          $display("FAIL pulse: got dir %0d at edge %0d, expected dir %0d at edge %0d", decr_step, edge_cnt, mon_e.dir, mon_e.edge_n);
        end
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    rst       = 1'b1;
    incr_lvl  = 1'b1;
    decr_lvl  = 1'b0;
    repeat_en = 1'b1;
    #2 rst = 1'b0;

    // Button held through reset never counts
    tick(3);
    check("reset_busy", busy, 1);
    check("reset_incr", incr_step, 0);
    check("reset_decr", decr_step, 0);
    rst = 1'b1;
    for (int i = 0; i < 10; i++) begin
      tick(1);
      check("held_after_reset_busy", busy, 1);
    end
    incr_lvl = 1'b0;
    tick(1);
    check("release_to_idle_busy", busy, 0);

    // Long hold with repeat
    k = edge_cnt + 1;
    incr_lvl = 1'b1;
    push(k, 0); push(k + 8, 0); push(k + 11, 0); push(k + 14, 0); push(k + 17, 0);
    tick(1);
    check("press_busy", busy, 1);
    tick(19);
    incr_lvl = 1'b0;
    tick(1);
    check("hold_release_busy", busy, 0);
    tick(2);

    // Two short decrement taps
    k = edge_cnt + 1;
    decr_lvl = 1'b1;
    push(k, 1); push(k + 5, 1);
    tick(3);
    decr_lvl = 1'b0;
    tick(2);
    check("tap_gap_busy", busy, 0);
    decr_lvl = 1'b1;
    tick(3);
    decr_lvl = 1'b0;
    tick(2);

    // Simultaneous press
    incr_lvl = 1'b1;
    decr_lvl = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick(1);
      check("conflict_busy", busy, 1);
    end
    incr_lvl = 1'b0;
    decr_lvl = 1'b0;
    tick(1);
    check("conflict_release_busy", busy, 0);

    // Conflict arriving during REPEAT
    k = edge_cnt + 1;
    incr_lvl = 1'b1;
    push(k, 0); push(k + 8, 0);
    tick(10);
    decr_lvl = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick(1);
      check("repeat_conflict_busy", busy, 1);
    end
    incr_lvl = 1'b0;
    tick(2);
    check("decr_still_high_busy", busy, 1);
    decr_lvl = 1'b0;
    tick(1);
    check("repeat_conflict_release_busy", busy, 0);

    // Repeat disabled, then re-enabled mid-hold
    k = edge_cnt + 1;
    repeat_en = 1'b0;
    incr_lvl  = 1'b1;
    push(k, 0);
    tick(30);
    check("no_repeat_busy", busy, 1);
    j = edge_cnt + 1;
    repeat_en = 1'b1;
    push(j + 7, 0);
    tick(9);
    incr_lvl = 1'b0;
    tick(1);
    check("reenable_release_busy", busy, 0);
    tick(2);

    // Reset while a repeat pulse is visible
    k = edge_cnt + 1;
    incr_lvl = 1'b1;
    push(k, 0); push(k + 8, 0);
    tick(11);
    @(posedge FPGA_clk);
    #1;
    check("pre_reset_pulse", incr_step, 1);
    rst = 1'b0;
    #1;
    check("async_reset_incr", incr_step, 0);
    check("async_reset_busy", busy, 1);
    tick(2);
    rst = 1'b1;
    tick(5);
    check("post_reset_held_busy", busy, 1);
    incr_lvl = 1'b0;
    tick(1);
    check("post_reset_release_busy", busy, 0);
    tick(3);

    check("scoreboard_empty", exp_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
